// File: rtl/bootram_loader.sv
// bootram_loader
//   Receives a framed boot image from a byte source (normally UART RX) and
//   writes it sequentially into the boot RAM starting at address 0.
//   The CPU is held in reset until the image is complete.
//   Frame: MAGIC, LEN_LO, LEN_HI, N data bytes, [CSUM].
//
// Build option:
//   BOOTLOADER_CHECKSUM_EN  adds a trailing modulo-256 checksum byte.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   boot_skip          in IDLE, jump straight to DONE without loading
//   rx_valid/rx_data   upstream byte; accepted when rx_valid && rx_ready
//   rx_ready           loader can take a byte this cycle
//   ram_ce/ram_wre     boot RAM write strobes (one cycle per data byte)
//   ram_ad/ram_din     boot RAM address / write data
//   cpu_resetn         CPU reset, released only in DONE
//   done               image loaded or load skipped
//   err                frame error (cleared by the next MAGIC byte)
module bootram_loader #(
   parameter int unsigned ADDR_W = 11,
   parameter logic [7:0]  MAGIC  = 8'hA5
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              boot_skip,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              ram_ce,
   output logic              ram_wre,
   output logic [ADDR_W-1:0] ram_ad,
   output logic [7:0]        ram_din,
   output logic              cpu_resetn,
   output logic              done,
   output logic              err
);

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [ADDR_W:0]   cnt_t;

   localparam logic [16:0] MaxLen = 17'(1) << ADDR_W;

   typedef enum logic [2:0] {
      StIdle,
      StLenLo,
      StLenHi,
      StData,
      StDone,
      StErr
`ifdef BOOTLOADER_CHECKSUM_EN
      , StCsum
`endif
   } state_t;

   state_t      state_q, state_d;
   logic        rdy_q, rdy_d;
   logic [7:0]  len_lo_q, len_lo_d;
   cnt_t        len_q, len_d;
   cnt_t        cnt_q, cnt_d;
   addr_t       addr_q, addr_d;
   logic        we_q, we_d;
   addr_t       ad_q, ad_d;
   logic [7:0]  din_q, din_d;
`ifdef BOOTLOADER_CHECKSUM_EN
   logic [7:0]  sum_q, sum_d;
`endif

   logic        accept;
   logic [15:0] len_full;
   logic        len_bad;
   cnt_t        cnt_inc;

   assign accept   = rx_valid & rdy_q;
   assign len_full = {rx_data, len_lo_q};
   assign len_bad  = (len_full == 16'd0) || ({1'b0, len_full} > MaxLen);
   assign cnt_inc  = cnt_q + cnt_t'(1);

   always_comb begin
      state_d  = state_q;
      len_lo_d = len_lo_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      we_d     = 1'b0;
      ad_d     = ad_q;
      din_d    = din_q;
`ifdef BOOTLOADER_CHECKSUM_EN
      sum_d    = sum_q;
`endif
      case (state_q)
         StIdle: begin
            // boot_skip wins even over a MAGIC byte accepted in the same cycle
            if (boot_skip) begin
               state_d = StDone;
            end else if (accept && (rx_data == MAGIC)) begin
               state_d = StLenLo;
            end
         end
         StLenLo: begin
            if (accept) begin
               len_lo_d = rx_data;
               state_d  = StLenHi;
            end
         end
         StLenHi: begin
            if (accept) begin
               if (len_bad) begin
                  state_d = StErr;
               end else begin
                  len_d   = len_full[ADDR_W:0];
                  cnt_d   = '0;
                  addr_d  = '0;
`ifdef BOOTLOADER_CHECKSUM_EN
                  sum_d   = 8'h00;
`endif
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (accept) begin
               we_d   = 1'b1;
               ad_d   = addr_q;
               din_d  = rx_data;
               // wraps to 0 after a full-size image; harmless since DATA is left
               addr_d = addr_q + addr_t'(1);
               cnt_d  = cnt_inc;
`ifdef BOOTLOADER_CHECKSUM_EN
               sum_d  = sum_q + rx_data;
               if (cnt_inc == len_q) state_d = StCsum;
`else
               if (cnt_inc == len_q) state_d = StDone;
`endif
            end
         end
`ifdef BOOTLOADER_CHECKSUM_EN
         StCsum: begin
            if (accept) begin
               state_d = (rx_data == sum_q) ? StDone : StErr;
            end
         end
`endif
         StDone: begin
            state_d = StDone;
         end
         StErr: begin
            if (accept && (rx_data == MAGIC)) begin
               state_d = StLenLo;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      rdy_d = (state_d != StDone);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= StIdle;
         rdy_q    <= 1'b0;
         len_lo_q <= 8'h00;
         len_q    <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         ad_q     <= '0;
         din_q    <= 8'h00;
`ifdef BOOTLOADER_CHECKSUM_EN
         sum_q    <= 8'h00;
`endif
      end else begin
         state_q  <= state_d;
         rdy_q    <= rdy_d;
         len_lo_q <= len_lo_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         ad_q     <= ad_d;
         din_q    <= din_d;
`ifdef BOOTLOADER_CHECKSUM_EN
         sum_q    <= sum_d;
`endif
      end
   end

   assign rx_ready   = rdy_q;
   assign ram_ce     = we_q;
   assign ram_wre    = we_q;
   assign ram_ad     = ad_q;
   assign ram_din    = din_q;
   assign done       = (state_q == StDone);
   assign cpu_resetn = (state_q == StDone);
   assign err        = (state_q == StErr);

endmodule

// File: tb/tb_bootram_loader.sv
// tb_bootram_loader
//   Self-checking bench for bootram_loader: a cycle table for the basic
//   frame, then hand-written sequences for errors, length limits, a full
//   2048-byte image, boot_skip, junk bytes and reset mid-load.
module tb_bootram_loader;

   logic        clk = 1'b0;
   logic        resetn;
   logic        boot_skip;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        ram_ce;
   logic        ram_wre;
   logic [10:0] ram_ad;
   logic [7:0]  ram_din;
   logic        cpu_resetn;
   logic        done;
   logic        err;

   bootram_loader #(.ADDR_W(11), .MAGIC(8'hA5)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .boot_skip  (boot_skip),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .ram_ce     (ram_ce),
      .ram_wre    (ram_wre),
      .ram_ad     (ram_ad),
      .ram_din    (ram_din),
      .cpu_resetn (cpu_resetn),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Boot RAM model and write log
   logic [7:0]  mem [0:2047];
   int          wr_count = 0;
   logic [10:0] last_ad = '0;

   always @(posedge clk) begin
      if (ram_ce && ram_wre) begin
         mem[ram_ad] <= ram_din;
         wr_count    <= wr_count + 1;
         last_ad     <= ram_ad;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn    = 1'b0;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      boot_skip = 1'b0;
      step();
      step();
      resetn = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok       = 1'b0;
      rx_valid = 1'b1;
      rx_data  = b;
      for (int i = 0; i < 16; i++) begin
         ok = rx_ready;
         step();
         if (ok) break;
      end
      rx_valid = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: byte %0h not accepted within 16 cycles", b);
      end
   endtask

   logic [7:0] payload [$];

   task automatic send_frame();
      logic [7:0]  cs;
      logic [15:0] n;
      cs = 8'h00;
      n  = 16'(payload.size());
      send_byte(8'hA5);
      send_byte(n[7:0]);
      send_byte(n[15:8]);
      foreach (payload[i]) begin
         send_byte(payload[i]);
         cs = cs + payload[i];
      end
`ifdef BOOTLOADER_CHECKSUM_EN
      send_byte(cs);
`endif
   endtask

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        rdy;
      logic        we;
      logic [10:0] ad;
      logic [7:0]  din;
      logic        dn;
   } vec_t;

   vec_t tbl [$];

   task automatic add_row(input logic v, input logic [7:0] d, input logic rdy, input logic we,
                          input logic [10:0] ad, input logic [7:0] din, input logic dn);
      vec_t r;
      r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.ad = ad; r.din = din; r.dn = dn;
      tbl.push_back(r);
   endtask

   initial begin
      int          wc0;
      int          bad_cnt;
      logic [20:0] act_v, exp_v;

      // ---- reset values
      do_reset();
      chk("reset_outputs",
          {rx_ready, ram_ce, ram_wre, ram_ad, ram_din, cpu_resetn, done, err},
          {1'b0, 1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 1'b0});

      // ---- frame A5 04 00 13 00 00 00 [13], cycle by cycle
      add_row(1'b0, 8'h00, 1'b0, 1'b0, 11'h0, 8'h00, 1'b0);
      add_row(1'b1, 8'hA5, 1'b1, 1'b0, 11'h0, 8'h00, 1'b0);
      add_row(1'b1, 8'h04, 1'b1, 1'b0, 11'h0, 8'h00, 1'b0);
      add_row(1'b1, 8'h00, 1'b1, 1'b0, 11'h0, 8'h00, 1'b0);
      add_row(1'b1, 8'h13, 1'b1, 1'b0, 11'h0, 8'h00, 1'b0);
      add_row(1'b1, 8'h00, 1'b1, 1'b1, 11'h0, 8'h13, 1'b0);
      add_row(1'b1, 8'h00, 1'b1, 1'b1, 11'h1, 8'h00, 1'b0);
      add_row(1'b1, 8'h00, 1'b1, 1'b1, 11'h2, 8'h00, 1'b0);
`ifdef BOOTLOADER_CHECKSUM_EN
      add_row(1'b1, 8'h13, 1'b1, 1'b1, 11'h3, 8'h00, 1'b0);
      add_row(1'b1, 8'hA5, 1'b0, 1'b0, 11'h0, 8'h00, 1'b1);
      add_row(1'b0, 8'h00, 1'b0, 1'b0, 11'h0, 8'h00, 1'b1);
`else
      add_row(1'b1, 8'hA5, 1'b0, 1'b1, 11'h3, 8'h00, 1'b1);
      add_row(1'b0, 8'h00, 1'b0, 1'b0, 11'h0, 8'h00, 1'b1);
`endif
      wc0 = wr_count;
      foreach (tbl[i]) begin
         act_v = {rx_ready, ram_ce, ram_wre, done, cpu_resetn, err,
                  tbl[i].we ? ram_ad : 11'h0, 1'b0};
         exp_v = {tbl[i].rdy, tbl[i].we, tbl[i].we, tbl[i].dn, tbl[i].dn, 1'b0,
                  tbl[i].we ? tbl[i].ad : 11'h0, 1'b0};
         chk($sformatf("frameA_row%0d_ctl", i), 64'(act_v), 64'(exp_v));
         if (tbl[i].we) chk($sformatf("frameA_row%0d_din", i), 64'(ram_din), 64'(tbl[i].din));
         rx_valid = tbl[i].v;
         rx_data  = tbl[i].d;
         step();
      end
      chk("frameA_write_count", 64'(wr_count - wc0), 64'd4);
      chk("frameA_mem", {32'h0, mem[0], mem[1], mem[2], mem[3]}, 64'h13000000);

`ifdef BOOTLOADER_CHECKSUM_EN
      // ---- bad checksum then recovery frame
      do_reset();
      wc0 = wr_count;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h34);
      chk("csum_bad_flags", {61'h0, err, cpu_resetn, done}, {61'h0, 3'b100});
      wc0 = wr_count;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h55); send_byte(8'h55);
      step();
      chk("csum_recover_flags", {61'h0, err, cpu_resetn, done}, {61'h0, 3'b011});
      chk("csum_recover_writes", 64'(wr_count - wc0), 64'd1);
      chk("csum_recover_mem0", 64'(mem[0]), 64'h55);
`endif

      // ---- illegal lengths 0 and 0x801
      do_reset();
      wc0 = wr_count;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      chk("len0_flags", {60'h0, err, cpu_resetn, done, rx_ready}, {60'h0, 4'b1001});
      send_byte(8'hA5);
      chk("err_cleared_by_magic", 64'(err), 64'd0);
      send_byte(8'h01); send_byte(8'h08);
      chk("len801_flags", {61'h0, err, cpu_resetn, done}, {61'h0, 3'b100});
      step();
      chk("len_err_no_writes", 64'(wr_count - wc0), 64'd0);

      // ---- full 2048-byte image
      do_reset();
      payload.delete();
      for (int i = 0; i < 2048; i++) payload.push_back(8'(i));
      wc0 = wr_count;
      send_frame();
      step(); step(); step();
      chk("full_done", {62'h0, done, cpu_resetn}, {62'h0, 2'b11});
      chk("full_write_count", 64'(wr_count - wc0), 64'd2048);
      chk("full_last_ad", 64'(last_ad), 64'h7FF);
      bad_cnt = 0;
      for (int i = 0; i < 2048; i++) if (mem[i] !== 8'(i)) bad_cnt++;
      chk("full_mem_errors", 64'(bad_cnt), 64'd0);

      // ---- boot_skip out of reset with MAGIC on the bus
      resetn    = 1'b0;
      boot_skip = 1'b1;
      rx_valid  = 1'b1;
      rx_data   = 8'hA5;
      step(); step();
      resetn = 1'b1;
      wc0 = wr_count;
      step();
      chk("skip_flags", {60'h0, done, cpu_resetn, err, rx_ready}, {60'h0, 4'b1100});
      step(); step();
      chk("skip_no_writes", 64'(wr_count - wc0), 64'd0);
      rx_valid  = 1'b0;
      boot_skip = 1'b0;

      // ---- junk bytes before MAGIC
      do_reset();
      wc0 = wr_count;
      send_byte(8'h00); send_byte(8'hFF);
      payload.delete();
      payload.push_back(8'h77);
      send_frame();
      step();
      chk("junk_done", {62'h0, done, err}, {62'h0, 2'b10});
      chk("junk_writes", 64'(wr_count - wc0), 64'd1);
      chk("junk_mem0", 64'(mem[0]), 64'h77);

      // ---- reset after 3rd data byte of an 8-byte frame
      do_reset();
      wc0 = wr_count;
      send_byte(8'hA5); send_byte(8'h08); send_byte(8'h00);
      send_byte(8'h10); send_byte(8'h11); send_byte(8'h12);
      resetn = 1'b0;
      step();
      chk("midreset_outputs",
          {rx_ready, ram_ce, ram_wre, ram_ad, ram_din, cpu_resetn, done, err},
          {1'b0, 1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 1'b0});
      step();
      chk("midreset_writes", 64'(wr_count - wc0), 64'd3);
      resetn = 1'b1;
      payload.delete();
      for (int i = 0; i < 8; i++) payload.push_back(8'hC0 + 8'(i));
      send_frame();
      step();
      chk("reload_done", {62'h0, done, cpu_resetn}, {62'h0, 2'b11});
      bad_cnt = 0;
      for (int i = 0; i < 8; i++) if (mem[i] !== (8'hC0 + 8'(i))) bad_cnt++;
      chk("reload_mem_errors", 64'(bad_cnt), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
